alu_multicycle: RTL

//  Multi-cycle integer ALU, the execute stage directly downstream of the processor control FSM.

---
 rtl/alu_multicycle.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: multi-cycle integer ALU sitting behind the processor control FSM.
//
// A start pulse in IDLE captures alu_op/operand_a/operand_b. Single-cycle ops
// spend one cycle in EXEC. MUL, when built, spends WIDTH cycles in MUL_ITER
// running a shift-add multiply. Both paths then pass through a write-back
// state. That state loads result/zero/overflow/illegal and pulses done.
//
// Ports:
//   clk        clock, rising edge
//   reset      synchronous, active-high; aborts any op in flight
//   start      request pulse, honoured only in IDLE when done is low
//   alu_op     000 ADD, 001 SUB, 010 AND, 011 OR, 100 CMP_EQ, 101 SLT, 110 MUL, 111 reserved
//   operand_a  first operand
//   operand_b  second operand
//   result     result of the last completed op
//   zero       result == 0
//   overflow   signed ADD/SUB overflow, or MUL product truncation
//   illegal    last completed op was unsupported
//   busy       op in flight; drops on the edge done rises
//   done       one-cycle completion pulse (DoneALU)
//
// Configuration macro ALU_MUL_EN: builds the iterative multiplier for op 110.
// When the macro is undefined, op 110 gets the same 1-cycle illegal response as op 111.
module alu_multicycle #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       alu_op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal,
    output logic             busy,
    output logic             done
);

    if (WIDTH < 4) begin : g_bad_width
        $error("alu_multicycle: WIDTH must be >= 4");
    end
    if ((64'd1 << CNT_W) <= 64'(WIDTH)) begin : g_bad_cnt
        $error("alu_multicycle: CNT_W too small for WIDTH iterations");
    end

    typedef enum logic [1:0] {StIdle, StExec, StMulIter, StDone} state_e;

    state_e           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    // Values computed by EXEC/MUL_ITER, published to the outputs in DONE.
    logic [WIDTH-1:0] res_stage_q, res_stage_d;
    logic             ovf_stage_q, ovf_stage_d, ill_stage_q, ill_stage_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d, overflow_q, overflow_d, illegal_q, illegal_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] sum, diff;
    assign sum  = a_q + b_q;
    assign diff = a_q - b_q;

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, acc_sum;
    logic [WIDTH-1:0]   mult_q, mult_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    assign acc_sum = acc_q + (mult_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        res_stage_d = res_stage_q;
        ovf_stage_d = ovf_stage_q;
        ill_stage_d = ill_stage_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef ALU_MUL_EN
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mult_d      = mult_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            StIdle: begin
                // done_q high means this is the completion cycle; start is dropped there.
                if (start && !done_q) begin
                    op_d   = alu_op;
                    a_d    = operand_a;
                    b_d    = operand_b;
                    busy_d = 1'b1;
                    state_d = StExec;
`ifdef ALU_MUL_EN
                    if (alu_op == 3'b110) begin
                        state_d = StMulIter;
                        cnt_d   = '0;
                        acc_d   = '0;
                        mcand_d = {{WIDTH{1'b0}}, operand_a};
                        mult_d  = operand_b;
                    end
`endif
                end
            end
            StExec: begin
                res_stage_d = '0;
                ovf_stage_d = 1'b0;
                ill_stage_d = 1'b0;
                case (op_q)
                    3'b000: begin
                        res_stage_d = sum;
                        ovf_stage_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                                      (sum[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    3'b001: begin
                        res_stage_d = diff;
                        ovf_stage_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                                      (diff[WIDTH-1] != a_q[WIDTH-1]);
                    end
                    3'b010: res_stage_d = a_q & b_q;
                    3'b011: res_stage_d = a_q | b_q;
                    3'b100: res_stage_d = {{(WIDTH-1){1'b0}}, a_q == b_q};
                    3'b101: res_stage_d = {{(WIDTH-1){1'b0}}, $signed(a_q) < $signed(b_q)};
                    // 110 reaches EXEC only without the multiplier; 111 is reserved.
                    default: ill_stage_d = 1'b1;
                endcase
                state_d = StDone;
            end
`ifdef ALU_MUL_EN
            StMulIter: begin
                acc_d   = acc_sum;
                mcand_d = mcand_q << 1;
                mult_d  = mult_q >> 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    res_stage_d = acc_sum[WIDTH-1:0];
                    ovf_stage_d = |acc_sum[2*WIDTH-1:WIDTH];
                    ill_stage_d = 1'b0;
                    state_d     = StDone;
                end
            end
`endif
            StDone: begin
                result_d   = res_stage_q;
                zero_d     = (res_stage_q == '0);
                overflow_d = ovf_stage_q;
                illegal_d  = ill_stage_q;
                done_d     = 1'b1;
                busy_d     = 1'b0;
                state_d    = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_stage_q <= '0;
            ovf_stage_q <= 1'b0;
            ill_stage_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ALU_MUL_EN
            acc_q       <= '0;
            mcand_q     <= '0;
            mult_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_stage_q <= res_stage_d;
            ovf_stage_q <= ovf_stage_d;
            ill_stage_q <= ill_stage_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ALU_MUL_EN
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mult_q      <= mult_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign result   = result_q;
    assign zero     = zero_q;
    assign overflow = overflow_q;
    assign illegal  = illegal_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule
